cnn_mac_engine: RTL and testbench

Compute sequencer that sits directly downstream of the CNN parameter/image RAM peripheral. It reads weights, pixels and a bias out of that RAM over its word-addressed 16-bit port and computes one signed dot product. It post-processes the result with shift, bias, optional ReLU and saturation, then writes the 16-bit result back into the same RAM. Software launches it with start and polls busy/done.

---
 rtl/cnn_mac_engine.sv | 201 ++++++++++++++++++++
 tb/tb_cnn_mac_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mac_engine.sv
// Dot-product sequencer: reads bias, weights and pixels from a word RAM,
// accumulates signed products, post-processes and writes the 16-bit result back.
module cnn_mac_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] bias_addr,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic              mem_chipselect,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_writedata,
    input  logic [15:0]       mem_readdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ZERO    = 3'd1,
        RD_BIAS = 3'd2,
        RD_W    = 3'd3,
        RD_X    = 3'd4,
        MAC     = 3'd5,
        POST    = 3'd6,
        WRITE   = 3'd7
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t state;
    state_t next_state;

    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] x_base_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [4:0]        shift_q;
    logic              relu_q;
    logic [LEN_W-1:0]  idx;
    logic [15:0]       bias_q;
    logic [15:0]       w_q;
    logic signed [ACC_W-1:0] acc;
    logic [15:0]       res_next;

    logic [LEN_W-1:0]  idx_next;
    logic [ADDR_W-1:0] addr_next;
    logic              read_next;
    logic              write_next;
    logic              last_elem;

    logic signed [31:0]      w_ext;
    logic signed [31:0]      x_ext;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] post_t;
    logic [15:0]             post_val;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state, element index and next memory command
    always_comb begin
        next_state = state;
        idx_next   = idx;
        addr_next  = '0;
        read_next  = 1'b0;
        write_next = 1'b0;
        last_elem  = (idx == len_q - LEN_W'(1));

        case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    next_state = (len == '0) ? ZERO : RD_BIAS;
                end
            end
            ZERO:    next_state = IDLE;
            RD_BIAS: next_state = RD_W;
            RD_W:    next_state = RD_X;
            RD_X:    next_state = MAC;
            MAC: begin
                if (last_elem) begin
                    next_state = POST;
                end else begin
                    idx_next   = idx + LEN_W'(1);
                    next_state = RD_W;
                end
            end
            POST:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // RD_BIAS is only entered from IDLE, so the live bias_addr is the one being latched
        case (next_state)
            RD_BIAS: begin
                addr_next = bias_addr;
                read_next = 1'b1;
            end
            RD_W: begin
                addr_next = w_base_q + ADDR_W'(idx_next);
                read_next = 1'b1;
            end
            RD_X: begin
                addr_next = x_base_q + ADDR_W'(idx);
                read_next = 1'b1;
            end
            WRITE: begin
                addr_next  = out_addr_q;
                write_next = 1'b1;
            end
            default: begin
                addr_next = '0;
            end
        endcase
    end

    // Product, shift, bias, ReLU and saturation
    always_comb begin
        w_ext   = {{16{w_q[15]}}, w_q};
        x_ext   = {{16{mem_readdata[15]}}, mem_readdata};
        prod    = w_ext * x_ext;
        shifted = acc >>> shift_q;
        post_t  = shifted + {{(ACC_W-16){bias_q[15]}}, bias_q};
        if (relu_q && post_t[ACC_W-1]) post_t = '0;
        if (post_t > SAT_MAX)      post_val = 16'h7FFF;
        else if (post_t < SAT_MIN) post_val = 16'h8000;
        else                       post_val = post_t[15:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q          <= '0;
            w_base_q       <= '0;
            x_base_q       <= '0;
            out_addr_q     <= '0;
            shift_q        <= '0;
            relu_q         <= 1'b0;
            idx            <= '0;
            bias_q         <= '0;
            w_q            <= '0;
            acc            <= '0;
            res_next       <= '0;
            result         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
        end else begin
            idx            <= idx_next;
            busy           <= (next_state != IDLE);
            done           <= (next_state == ZERO) || (state == WRITE);
            mem_read       <= read_next;
            mem_write      <= write_next;
            mem_chipselect <= read_next | write_next;
            mem_address    <= addr_next;
            mem_writedata  <= write_next ? post_val : 16'h0000;

            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q      <= len;
                        w_base_q   <= w_base;
                        x_base_q   <= x_base;
                        out_addr_q <= out_addr;
                        shift_q    <= shift;
                        relu_q     <= relu_en;
                        acc        <= '0;
                    end
                end
                RD_W:  if (idx == '0) bias_q <= mem_readdata;
                RD_X:  w_q <= mem_readdata;
                MAC:   acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
                POST:  res_next <= post_val;
                WRITE: result <= res_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mac_engine.sv
// Directed self-checking bench for cnn_mac_engine with a registered-read RAM model.
module tb_cnn_mac_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [15:0] w_base;
    logic [15:0] x_base;
    logic [15:0] bias_addr;
    logic [15:0] out_addr;
    logic [4:0]  shift;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        mem_chipselect;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;

    logic [15:0] ram [0:65535];
    logic [15:0] rd_hist [0:255];
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    int          rd_cnt;
    int          wr_cnt;
    int          both_cnt;

    int errors;
    int checks;

    cnn_mac_engine dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .len            (len),
        .w_base         (w_base),
        .x_base         (x_base),
        .bias_addr      (bias_addr),
        .out_addr       (out_addr),
        .shift          (shift),
        .relu_en        (relu_en),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .mem_chipselect (mem_chipselect),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, plus a bench load port and access logging
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        if (mem_write) begin
            ram[mem_address] <= mem_writedata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) begin
            mem_readdata <= ram[mem_address];
            rd_hist[rd_cnt & 255] <= mem_address;
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Launch one run; cyc = edges after the accepting edge until done is seen (-1 on timeout)
    task automatic run(input logic [7:0] l, input logic [15:0] wb, input logic [15:0] xb,
                       input logic [15:0] ba, input logic [15:0] oa, input logic [4:0] sh,
                       input logic re, output int cyc);
        start = 1'b1; len = l; w_base = wb; x_base = xb;
        bias_addr = ba; out_addr = oa; shift = sh; relu_en = re;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = 8'hA5; w_base = 16'hDEAD; x_base = 16'hBEEF;
        bias_addr = 16'h7777; out_addr = 16'h6666; shift = 5'd31; relu_en = ~re;
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, mem_read, mem_write, mem_chipselect} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_read, mem_write, mem_chipselect});
        end
        checks++;
        if ({result, mem_address, mem_writedata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {result, mem_address, mem_writedata});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int cyc;
        poke(16'h0010, 16'd2); poke(16'h0011, 16'hFFFD); poke(16'h0012, 16'd4);
        poke(16'h0020, 16'd5); poke(16'h0021, 16'd6);    poke(16'h0022, 16'd7);
        poke(16'h0030, 16'd10);
        run(8'd3, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 5'd0, 1'b0, cyc);
        checks++;
        if (cyc != 12) begin
            errors++; $display("FAIL basic_latency: got %0d want 12", cyc);
        end
        checks++;
        if (result !== 16'd30) begin
            errors++; $display("FAIL basic_result: got %h want %h", result, 16'd30);
        end
        checks++;
        if (ram[16'h0040] !== 16'd30) begin
            errors++; $display("FAIL basic_ram: got %h want %h", ram[16'h0040], 16'd30);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_done_pulse: got done,busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_saturation;
        int cyc;
        poke(16'h0050, 16'd300); poke(16'h0051, 16'd300);
        poke(16'h0052, 16'hFED4); poke(16'h0070, 16'd0);
        run(8'd1, 16'h0050, 16'h0051, 16'h0070, 16'h0041, 5'd0, 1'b0, cyc);
        checks++;
        if (result !== 16'h7FFF || ram[16'h0041] !== 16'h7FFF) begin
            errors++; $display("FAIL sat_pos: got %h/%h want 7fff", result, ram[16'h0041]);
        end
        run(8'd1, 16'h0052, 16'h0051, 16'h0070, 16'h0042, 5'd0, 1'b0, cyc);
        checks++;
        if (result !== 16'h8000 || ram[16'h0042] !== 16'h8000) begin
            errors++; $display("FAIL sat_neg: got %h/%h want 8000", result, ram[16'h0042]);
        end
    endtask

    task automatic test_relu;
        int cyc;
        poke(16'h0053, 16'hFFFF); poke(16'h0054, 16'd5);
        run(8'd1, 16'h0053, 16'h0054, 16'h0070, 16'h0043, 5'd0, 1'b1, cyc);
        checks++;
        if (result !== 16'h0000) begin
            errors++; $display("FAIL relu_on: got %h want 0000", result);
        end
        run(8'd1, 16'h0053, 16'h0054, 16'h0070, 16'h0044, 5'd0, 1'b0, cyc);
        checks++;
        if (result !== 16'hFFFB || ram[16'h0044] !== 16'hFFFB) begin
            errors++; $display("FAIL relu_off: got %h/%h want fffb", result, ram[16'h0044]);
        end
    endtask

    task automatic test_fixed_point;
        int cyc;
        poke(16'h0058, 16'd256); poke(16'h0059, 16'd256);
        poke(16'h005A, 16'd256); poke(16'h005B, 16'd512);
        poke(16'h005C, 16'd1);
        run(8'd2, 16'h0058, 16'h005A, 16'h005C, 16'h0045, 5'd8, 1'b0, cyc);
        checks++;
        if (result !== 16'd769 || cyc != 9) begin
            errors++; $display("FAIL fixed_point: got %0d after %0d cycles want 769 after 9", result, cyc);
        end
    endtask

    task automatic test_len_zero;
        int cyc;
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(8'd0, 16'h0010, 16'h0020, 16'h0030, 16'h0046, 5'd0, 1'b0, cyc);
        checks++;
        if (cyc != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_done: got cycle %0d busy %b want cycle 0 busy 1", cyc, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 16'd769 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_state: got result %0d done %b busy %b want 769 0 0", result, done, busy);
        end
        checks++;
        if (rd_cnt != rd0 || wr_cnt != wr0) begin
            errors++; $display("FAIL zero_noaccess: got %0d reads %0d writes want 0 0", rd_cnt - rd0, wr_cnt - wr0);
        end
    endtask

    task automatic test_start_while_busy;
        int ndone;
        int wr0;
        poke(16'h0091, 16'h5555);
        wr0 = wr_cnt;
        start = 1'b1; len = 8'd1; w_base = 16'h0010; x_base = 16'h0020;
        bias_addr = 16'h0030; out_addr = 16'h0090; shift = 5'd0; relu_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 2);
            len = 8'd2;
            out_addr = 16'h0091;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) ndone++;
        end
        checks++;
        if (ndone != 1 || wr_cnt - wr0 != 1) begin
            errors++; $display("FAIL busy_start: got %0d dones %0d writes want 1 1", ndone, wr_cnt - wr0);
        end
        checks++;
        if (ram[16'h0090] !== 16'd20 || ram[16'h0091] !== 16'h5555 || result !== 16'd20) begin
            errors++; $display("FAIL busy_start_data: got %h %h %h want 0014 5555 0014",
                               ram[16'h0090], ram[16'h0091], result);
        end
    endtask

    task automatic test_wrap;
        int cyc;
        int base;
        poke(16'hFFFF, 16'd3); poke(16'h0000, 16'd4);
        poke(16'h0080, 16'd2); poke(16'h0081, 16'd5);
        base = rd_cnt;
        run(8'd2, 16'hFFFF, 16'h0080, 16'h0070, 16'h00A0, 5'd0, 1'b0, cyc);
        checks++;
        if (rd_cnt - base != 5 || rd_hist[(base + 1) & 255] !== 16'hFFFF || rd_hist[(base + 3) & 255] !== 16'h0000) begin
            errors++; $display("FAIL wrap_addr: got %0d reads w addrs %h %h want 5 ffff 0000",
                               rd_cnt - base, rd_hist[(base + 1) & 255], rd_hist[(base + 3) & 255]);
        end
        checks++;
        if (result !== 16'd26) begin
            errors++; $display("FAIL wrap_result: got %0d want 26", result);
        end
    endtask

    task automatic test_reset_mid;
        int wr0;
        int cyc;
        poke(16'h0013, 16'd1); poke(16'h0023, 16'd1); poke(16'h00B0, 16'h1234);
        wr0 = wr_cnt;
        start = 1'b1; len = 8'd4; w_base = 16'h0010; x_base = 16'h0020;
        bias_addr = 16'h0030; out_addr = 16'h00B0; shift = 5'd0; relu_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_read, mem_write, mem_chipselect} !== 5'b0 ||
            {result, mem_address, mem_writedata} !== 48'h0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b %h want 0 0",
                               {busy, done, mem_read, mem_write, mem_chipselect},
                               {result, mem_address, mem_writedata});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != wr0 || ram[16'h00B0] !== 16'h1234) begin
            errors++; $display("FAIL reset_mid_nowrite: got %0d writes ram %h want 0 1234",
                               wr_cnt - wr0, ram[16'h00B0]);
        end
        run(8'd3, 16'h0010, 16'h0020, 16'h0030, 16'h00B1, 5'd0, 1'b0, cyc);
        checks++;
        if (result !== 16'd30 || ram[16'h00B1] !== 16'd30 || cyc != 12) begin
            errors++; $display("FAIL reset_mid_rerun: got %0d ram %0d cyc %0d want 30 30 12",
                               result, ram[16'h00B1], cyc);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; len = '0; w_base = '0; x_base = '0;
        bias_addr = '0; out_addr = '0; shift = '0; relu_en = 1'b0;
        reset = 1'b0;
        #1;
        test_reset;
        test_basic;
        test_saturation;
        test_relu;
        test_fixed_point;
        test_len_zero;
        test_start_while_busy;
        test_wrap;
        test_reset_mid;
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
